cache_tag_ctrl: RTL and testbench
=================================

Name: cache_tag_ctrl

Overview:
Request-capture and tag-lookup stage directly upstream of cache_fsm. It samples the CPU request (cs, wr_rd_cpu, addr_cpu) and holds the direct-mapped tag, valid and dirty arrays. It produces hit, victim dirty status, wr_rd_cpu_q and the one-cycle cs_sampled_dly start pulse consumed by cache_fsm. It updates the arrays from the FSM's valid/dirty write strobes and supplies the victim and fill addresses for SDRAM transfers.

Parameters:
ADDR_W, 16, CPU address width
OFFSET_W, 4, block offset bits (16 words per line, matches addr_offset_counter)
INDEX_W, 3, index bits (8 lines)
TAG_W, ADDR_W-INDEX_W-OFFSET_W (9), tag bits; derived, not overridable
CNT_W, 16, width of hit/miss statistic counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cs  in  1  CPU chip select; request valid
wr_rd_cpu  in  1  1=write, 0=read
addr_cpu  in  ADDR_W  CPU byte/word address
rdy  in  1  cache_fsm transaction complete
valid  in  1  cache_fsm strobe: line filled; write tag_q, set valid
dirty  in  1  cache_fsm strobe: set dirty bit of current line
busy  out  1  request in flight; new cs ignored
cs_sampled_dly  out  1  one-cycle start pulse to cache_fsm
wr_rd_cpu_q  out  1  registered request type
hit  out  1  registered lookup result
dirty_input  out  1  victim line dirty (valid and dirty at index_q)
tag_q  out  TAG_W  captured request tag
index_q  out  INDEX_W  captured request index
victim_tag  out  TAG_W  stored tag at index_q (write-back address)
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter

Behaviour:
- Reset (async): every valid[], dirty[] and tag[] entry = 0. All outputs = 0. Counters = 0. Capture state returns to IDLE.
- States: IDLE, LOOKUP, WAIT.
- IDLE: on a rising edge with cs=1, register addr_cpu fields into tag_q/index_q and wr_rd_cpu into wr_rd_cpu_q. Set busy=1 and go to LOOKUP.
- LOOKUP (one cycle): register hit = valid[index_q] && tag[index_q]==tag_q, and dirty_input = valid[index_q] && dirty[index_q]. Register victim_tag = tag[index_q]. Drive cs_sampled_dly=1 on the following cycle, aligned with the now-valid hit and dirty_input. Increment hit_count or miss_count, saturating at all-ones. Go to WAIT.
- Latency: cs sampled at edge N; hit, dirty_input and cs_sampled_dly valid during cycle N+2. cs_sampled_dly is exactly one cycle wide.
- WAIT: hit, dirty_input, victim_tag and wr_rd_cpu_q are held stable. On rdy=1, busy clears and the state returns to IDLE on the same edge. cs may be accepted on the next edge.
- cs while busy=1: ignored; no capture, no pulse, no counter change.
- Array writes, any state, at index_q:
  - valid=1: tag[index_q] <= tag_q; valid[index_q] <= 1; dirty[index_q] <= 0.
  - dirty=1: dirty[index_q] <= 1.
  - valid and dirty in the same cycle: tag written, valid=1, dirty=1 (dirty wins).
- Array writes do not alter the held hit/dirty_input of the current request.
- Lookup of an index written in the same cycle sees the old contents (read-before-write).
- rdy=1 in IDLE or LOOKUP: ignored.
- Reset mid-transaction: arrays cleared, state returns to IDLE, busy=0, cs_sampled_dly not issued.

Optional Feature:
REQ_QUEUE_EN
- Defined: a one-entry pending buffer captures cs/wr_rd_cpu/addr_cpu while busy=1 (first request wins; further cs dropped). On rdy, the state goes to LOOKUP with the pending entry instead of IDLE. Its cs_sampled_dly pulse arrives 2 cycles after rdy. busy stays 1 across the handoff. Reset clears the buffer.
- Undefined: cs while busy is ignored, as in Behaviour.

Test Plan:
- Reset, then cs=1 read of addr 0x1230 -> cs_sampled_dly pulse at cycle N+2 with hit=0, dirty_input=0, miss_count=1, busy=1 until rdy.
- After fill (valid pulse, then rdy) to 0x1230, read 0x1234 -> hit=1, dirty_input=0, hit_count=1.
- Write hit on 0x1230 with dirty pulse, then read 0x5230 (same index 3, different tag) -> hit=0, dirty_input=1, victim_tag=tag of 0x1230.
- cs pulsed twice during WAIT -> no extra cs_sampled_dly, counters unchanged; with REQ_QUEUE_EN, exactly one queued pulse 2 cycles after rdy.
- Simultaneous valid and dirty strobes -> next lookup of that line: hit=1, dirty_input=1. Counter preloaded to 0xFFFF stays 0xFFFF on further hits.
- Assert rst during WAIT -> busy=0 and all lines invalid; re-read of the same address misses.

Source files
------------

// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl: request capture and direct-mapped tag lookup stage feeding cache_fsm.
// Holds tag/valid/dirty arrays, produces hit/victim status and a one-cycle start pulse.
// Optional feature macro: REQ_QUEUE_EN (one-entry pending request buffer while busy).
module cache_tag_ctrl #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned OFFSET_W = 4,
    parameter int unsigned INDEX_W  = 3,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cs,
    input  logic               wr_rd_cpu,
    input  logic [ADDR_W-1:0]  addr_cpu,
    input  logic               rdy,
    input  logic               valid,
    input  logic               dirty,
    output logic               busy,
    output logic               cs_sampled_dly,
    output logic               wr_rd_cpu_q,
    output logic               hit,
    output logic               dirty_input,
    output logic [TAG_W-1:0]   tag_q,
    output logic [INDEX_W-1:0] index_q,
    output logic [TAG_W-1:0]   victim_tag,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   miss_count
);

    localparam int unsigned NUM_LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               cs_sampled_dly_q, cs_sampled_dly_d;
    logic               wr_rd_cpu_d;
    logic               hit_q, hit_d;
    logic               dirty_input_q, dirty_input_d;
    logic [TAG_W-1:0]   tag_d;
    logic [INDEX_W-1:0] index_d;
    logic [TAG_W-1:0]   victim_tag_q, victim_tag_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;
    logic [CNT_W-1:0]   miss_count_q, miss_count_d;

    logic [TAG_W-1:0]     tag_mem_q [NUM_LINES];
    logic [TAG_W-1:0]     tag_mem_d [NUM_LINES];
    logic [NUM_LINES-1:0] valid_mem_q, valid_mem_d;
    logic [NUM_LINES-1:0] dirty_mem_q, dirty_mem_d;

    logic [TAG_W-1:0]   req_tag_c;
    logic [INDEX_W-1:0] req_index_c;
    logic               unused_offset;

`ifdef REQ_QUEUE_EN
    logic               pend_v_q, pend_v_d;
    logic               pend_wr_q, pend_wr_d;
    logic [TAG_W-1:0]   pend_tag_q, pend_tag_d;
    logic [INDEX_W-1:0] pend_index_q, pend_index_d;
`endif

    // Split the incoming CPU address into tag and index; offset is not needed here
    assign req_tag_c     = addr_cpu[ADDR_W-1 -: TAG_W];
    assign req_index_c   = addr_cpu[OFFSET_W +: INDEX_W];
    assign unused_offset = ^addr_cpu[OFFSET_W-1:0];

    assign busy           = busy_q;
    assign cs_sampled_dly = cs_sampled_dly_q;
    assign hit            = hit_q;
    assign dirty_input    = dirty_input_q;
    assign victim_tag     = victim_tag_q;
    assign hit_count      = hit_count_q;
    assign miss_count     = miss_count_q;

    // Capture FSM: next state, lookup results and statistics
    always_comb begin
        state_d          = state_q;
        busy_d           = busy_q;
        cs_sampled_dly_d = 1'b0;
        wr_rd_cpu_d      = wr_rd_cpu_q;
        hit_d            = hit_q;
        dirty_input_d    = dirty_input_q;
        tag_d            = tag_q;
        index_d          = index_q;
        victim_tag_d     = victim_tag_q;
        hit_count_d      = hit_count_q;
        miss_count_d     = miss_count_q;
`ifdef REQ_QUEUE_EN
        pend_v_d         = pend_v_q;
        pend_wr_d        = pend_wr_q;
        pend_tag_d       = pend_tag_q;
        pend_index_d     = pend_index_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cs) begin
                    tag_d       = req_tag_c;
                    index_d     = req_index_c;
                    wr_rd_cpu_d = wr_rd_cpu;
                    busy_d      = 1'b1;
                    state_d     = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_d            = valid_mem_q[index_q] && (tag_mem_q[index_q] == tag_q);
                dirty_input_d    = valid_mem_q[index_q] && dirty_mem_q[index_q];
                victim_tag_d     = tag_mem_q[index_q];
                cs_sampled_dly_d = 1'b1;
                if (hit_d) begin
                    if (hit_count_q != '1) hit_count_d = hit_count_q + CNT_W'(1);
                end else begin
                    if (miss_count_q != '1) miss_count_d = miss_count_q + CNT_W'(1);
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rdy) begin
`ifdef REQ_QUEUE_EN
                    if (pend_v_q) begin
                        // Hand the buffered request straight to lookup; busy stays set
                        tag_d       = pend_tag_q;
                        index_d     = pend_index_q;
                        wr_rd_cpu_d = pend_wr_q;
                        pend_v_d    = 1'b0;
                        state_d     = S_LOOKUP;
                    end else if (cs) begin
                        tag_d       = req_tag_c;
                        index_d     = req_index_c;
                        wr_rd_cpu_d = wr_rd_cpu;
                        state_d     = S_LOOKUP;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
`else
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
`ifdef REQ_QUEUE_EN
        // First request arriving while busy is buffered; later ones are dropped
        if (busy_q && cs && !pend_v_q && !(state_q == S_WAIT && rdy)) begin
            pend_v_d     = 1'b1;
            pend_wr_d    = wr_rd_cpu;
            pend_tag_d   = req_tag_c;
            pend_index_d = req_index_c;
        end
`endif
    end

    // Array updates from fill/dirty strobes; dirty strobe wins over the valid clear
    always_comb begin
        tag_mem_d   = tag_mem_q;
        valid_mem_d = valid_mem_q;
        dirty_mem_d = dirty_mem_q;
        if (valid) begin
            tag_mem_d[index_q]   = tag_q;
            valid_mem_d[index_q] = 1'b1;
            dirty_mem_d[index_q] = 1'b0;
        end
        if (dirty) begin
            dirty_mem_d[index_q] = 1'b1;
        end
    end

    // State, outputs and arrays; async reset clears everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            busy_q           <= 1'b0;
            cs_sampled_dly_q <= 1'b0;
            wr_rd_cpu_q      <= 1'b0;
            hit_q            <= 1'b0;
            dirty_input_q    <= 1'b0;
            tag_q            <= '0;
            index_q          <= '0;
            victim_tag_q     <= '0;
            hit_count_q      <= '0;
            miss_count_q     <= '0;
            tag_mem_q        <= '{default: '0};
            valid_mem_q      <= '0;
            dirty_mem_q      <= '0;
        end else begin
            state_q          <= state_d;
            busy_q           <= busy_d;
            cs_sampled_dly_q <= cs_sampled_dly_d;
            wr_rd_cpu_q      <= wr_rd_cpu_d;
            hit_q            <= hit_d;
            dirty_input_q    <= dirty_input_d;
            tag_q            <= tag_d;
            index_q          <= index_d;
            victim_tag_q     <= victim_tag_d;
            hit_count_q      <= hit_count_d;
            miss_count_q     <= miss_count_d;
            tag_mem_q        <= tag_mem_d;
            valid_mem_q      <= valid_mem_d;
            dirty_mem_q      <= dirty_mem_d;
        end
    end

`ifdef REQ_QUEUE_EN
    // Pending request buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v_q     <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_tag_q   <= '0;
            pend_index_q <= '0;
        end else begin
            pend_v_q     <= pend_v_d;
            pend_wr_q    <= pend_wr_d;
            pend_tag_q   <= pend_tag_d;
            pend_index_q <= pend_index_d;
        end
    end
`endif

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Scoreboard bench for cache_tag_ctrl: drivers push expected lookup results,
// a negedge monitor pops and compares whenever cs_sampled_dly is seen.
module tb_cache_tag_ctrl;

    localparam int unsigned CW  = 4;   // small counters so saturation is reachable
    localparam int          SAT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0;
    logic        wr_rd_cpu = 1'b0;
    logic [15:0] addr_cpu = 16'h0;
    logic        rdy = 1'b0;
    logic        valid = 1'b0;
    logic        dirty = 1'b0;
    logic        busy, cs_sampled_dly, wr_rd_cpu_q, hit, dirty_input;
    logic [8:0]  tag_q, victim_tag;
    logic [2:0]  index_q;
    logic [CW-1:0] hit_count, miss_count;

    cache_tag_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cs(cs), .wr_rd_cpu(wr_rd_cpu), .addr_cpu(addr_cpu),
        .rdy(rdy), .valid(valid), .dirty(dirty), .busy(busy),
        .cs_sampled_dly(cs_sampled_dly), .wr_rd_cpu_q(wr_rd_cpu_q), .hit(hit),
        .dirty_input(dirty_input), .tag_q(tag_q), .index_q(index_q),
        .victim_tag(victim_tag), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       hit;
        logic       di;
        logic [8:0] vt;
        logic       wr;
        int         hc;
        int         mc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   hc_m = 0;
    int   mc_m = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: record the expected lookup and update reference counters
    task automatic push_exp(input logic eh, input logic edi, input logic [8:0] evt,
                            input logic w);
        exp_t e;
        if (eh) begin
            if (hc_m < SAT) hc_m++;
        end else begin
            if (mc_m < SAT) mc_m++;
        end
        e.cyc = cyc; e.hit = eh; e.di = edi; e.vt = evt; e.wr = w;
        e.hc = hc_m; e.mc = mc_m;
        exp_q.push_back(e);
    endtask

    // Monitor: every start pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && cs_sampled_dly) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc, e.cyc + 2);
                chk("hit", int'(hit), int'(e.hit));
                chk("dirty_input", int'(dirty_input), int'(e.di));
                chk("victim_tag", int'(victim_tag), int'(e.vt));
                chk("wr_rd_cpu_q", int'(wr_rd_cpu_q), int'(e.wr));
                chk("hit_count", int'(hit_count), e.hc);
                chk("miss_count", int'(miss_count), e.mc);
            end
        end
    end

    // Issue one request; returns at the negedge where the start pulse is expected
    task automatic req(input logic [15:0] a, input logic w, input logic eh,
                       input logic edi, input logic [8:0] evt);
        @(negedge clk);
        cs = 1'b1; addr_cpu = a; wr_rd_cpu = w;
        push_exp(eh, edi, evt, w);
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        chk("busy_in_wait", int'(busy), 1);
    endtask

    // Optional array strobes, then rdy; checks the transaction retired cleanly
    task automatic finish(input logic sv, input logic sd);
        @(negedge clk);
        valid = sv; dirty = sd;
        @(negedge clk);
        valid = 1'b0; dirty = 1'b0; rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        chk("busy_after_rdy", int'(busy), 0);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pulse", int'(cs_sampled_dly), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_dirty_input", int'(dirty_input), 0);
        chk("rst_hit_count", int'(hit_count), 0);
        chk("rst_miss_count", int'(miss_count), 0);

        // rdy while idle does nothing
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        @(negedge clk);
        chk("idle_rdy_busy", int'(busy), 0);

        // Cold miss on 0x1230 (index 3, tag 0x24), then fill
        req(16'h1230, 1'b0, 1'b0, 1'b0, 9'h000);
        chk("tag_q", int'(tag_q), 'h24);
        chk("index_q", int'(index_q), 3);
        finish(1'b1, 1'b0);

        // Read hit in the same line
        req(16'h1234, 1'b0, 1'b1, 1'b0, 9'h024);
        finish(1'b0, 1'b0);

        // Write hit, mark dirty
        req(16'h1230, 1'b1, 1'b1, 1'b0, 9'h024);
        finish(1'b0, 1'b1);

        // Conflict miss on index 3 with dirty victim; cs pulsed twice during WAIT
        req(16'h5230, 1'b0, 1'b0, 1'b1, 9'h024);
        @(negedge clk);
        cs = 1'b1; addr_cpu = 16'h0010; wr_rd_cpu = 1'b0;
        @(negedge clk);
        addr_cpu = 16'h0020; wr_rd_cpu = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        chk("wait_cs_hit_count", int'(hit_count), hc_m);
        chk("wait_cs_miss_count", int'(miss_count), mc_m);
        rdy = 1'b1;
`ifdef REQ_QUEUE_EN
        push_exp(1'b0, 1'b0, 9'h000, 1'b0);
        @(negedge clk);
        rdy = 1'b0;
        chk("queued_busy", int'(busy), 1);
        @(negedge clk);
        finish(1'b0, 1'b0);
`else
        @(negedge clk);
        rdy = 1'b0;
        chk("busy_after_rdy", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk("no_extra_pulse", exp_q.size(), 0);
`endif

        // Simultaneous valid+dirty on index 5 (0x0450, tag 0x008)
        req(16'h0450, 1'b0, 1'b0, 1'b0, 9'h000);
        finish(1'b1, 1'b1);
        req(16'h0450, 1'b0, 1'b1, 1'b1, 9'h008);
        finish(1'b0, 1'b0);

        // Hit counter saturation
        for (int i = 0; i < 14; i++) begin
            req(16'h1234, 1'b0, 1'b1, 1'b1, 9'h024);
            finish(1'b0, 1'b0);
        end
        chk("hit_count_saturated", int'(hit_count), SAT);

        // Reset while waiting for rdy
        req(16'h1234, 1'b0, 1'b1, 1'b1, 9'h024);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_hit", int'(hit), 0);
        chk("midrst_hit_count", int'(hit_count), 0);
        chk("midrst_miss_count", int'(miss_count), 0);
        rst = 1'b0;
        hc_m = 0;
        mc_m = 0;
        @(negedge clk);
        chk("midrst_no_pulse", int'(cs_sampled_dly), 0);
        req(16'h1234, 1'b0, 1'b0, 1'b0, 9'h000);
        finish(1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("final_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
